// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the instruction fetch stage: FSM state encoding,
// the NOP word loaded into the IF/ID register on reset, and PC helpers.
package fetch_stage_pkg;

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response
  // belongs to a squashed fetch and will be thrown away.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Instruction addresses are word aligned; low two bits of a target are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding memory request and an
// IF/ID output register.
//
// Handshakes:
//   imem_req/imem_addr is a one-cycle request pulse, accepted by memory on the
//   rising edge where imem_req=1. imem_rvalid/imem_rdata returns the word one
//   or more cycles later; only one request is ever in flight.
//   id_valid/id_stall toward decode: an instruction is consumed on a rising
//   edge where id_valid=1 and id_stall=0; while id_stall=1 the IF/ID register
//   holds. A redirect always wins: it squashes the IF/ID register and any
//   in-flight fetch, and the target is requested once the memory is free.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         id_stall,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc4,
  output logic [5:0]   id_op,
  output logic [5:0]   id_func,
  output fetch_state_e dbg_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         issue;
  logic [31:0]  pc_plus4;

  // Sequential PC increment; wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + PC_STEP;

  // Next-state, PC and IF/ID register update; redirect takes priority over all.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    issue   = 1'b0;

    // Decode took the presented instruction this cycle.
    if (valid_q && !id_stall) begin
      valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d    = align_word(redirect_pc);
      valid_d = 1'b0;
      unique case (state_q)
        // An in-flight fetch is stale; if its response is here now it is
        // simply discarded, otherwise remember to discard it later.
        S_WAIT, S_DROP: state_d = imem_rvalid ? S_IDLE : S_DROP;
        default:        state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Late responses in IDLE are ignored.
          if (!valid_q || !id_stall) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, PC and IF/ID register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Request is held off while reset is asserted so memory never sees a
  // fetch before the first edge after release.
  assign imem_req  = issue & rst_n;
  assign imem_addr = pc_q;

  assign id_valid  = valid_q;
  assign id_instr  = instr_q;
  assign id_pc4    = pc4_q;
  assign id_op     = instr_q[31:26];
  assign id_func   = instr_q[5:0];
  assign dbg_state = state_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_req  output  1  one-cycle fetch request pulse.
REQ-005 SHALL have port: imem_addr  output  32  fetch address, valid when imem_req=1.
REQ-006 SHALL have port: imem_rvalid  input  1  response strobe, >=1 cycle after request.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-008 SHALL have port: redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port: redirect_pc  input  32  redirect target.
REQ-010 SHALL have port: id_stall  input  1  decode cannot accept; hold outputs.
REQ-011 SHALL have port: id_valid  output  1  instruction presented to decode.
REQ-012 SHALL have port: id_instr  output  32  fetched instruction.
REQ-013 SHALL have port: id_pc4  output  32  address of id_instr plus 4.
REQ-014 SHALL have port: id_op  output  6  id_instr[31:26], opcode to control decode.
REQ-015 SHALL have port: id_func  output  6  id_instr[5:0], function field to ALU control.

Function
REQ-016 SHALL implement FSM states IDLE (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-017 SHALL issue imem_req=1, imem_addr=pc, and enter WAIT, when in IDLE, redirect_valid=0, and (id_valid=0 or id_stall=0).
REQ-018 SHALL keep at most one request outstanding; imem_req SHALL be 0 in WAIT and DROP.
REQ-019 SHALL, in WAIT with imem_rvalid=1 and no redirect, load id_instr=imem_rdata, id_pc4=pc+4, id_valid=1, pc=pc+4, and go IDLE.
REQ-020 SHALL clear id_valid when id_valid=1, id_stall=0, and no new instruction loads that cycle.
REQ-021 SHALL hold id_valid, id_instr, id_pc4 stable while id_valid=1 and id_stall=1.
REQ-022 SHALL, on redirect_valid=1 in any state, set pc=redirect_pc with bits [1:0] forced to 0 and id_valid=0; redirect overrides id_stall.
REQ-023 SHALL, on redirect in WAIT with imem_rvalid=0, go DROP; with imem_rvalid=1 same cycle, discard rdata and go IDLE.
REQ-024 SHALL, in DROP, discard the response on imem_rvalid and go IDLE; redirect in DROP updates pc and stays DROP.
REQ-025 SHALL ignore imem_rvalid in IDLE.
REQ-026 SHALL not issue imem_req in a cycle with redirect_valid=1; the first request to the target issues the next cycle (IDLE) or after the dropped response.
REQ-027 SHALL wrap pc+4 modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-028 SHALL drive id_op and id_func combinationally from id_instr.
REQ-029 SHALL sustain peak throughput of one instruction per two cycles with one-cycle memory latency.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, pc=RESET_PC, id_valid=0, id_instr=0, id_pc4=0, imem_req=0.
REQ-031 SHALL issue the first request (addr=RESET_PC) on the first rising edge after rst_n deasserts.
REQ-032 SHALL, on reset mid-request, ignore any late imem_rvalid arriving after reset release while in IDLE.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2) and the NOP word 32'h0 in the shared CPU package.
REQ-034 SHALL be a single module; the IF/ID output register is not split into a sub-module.

Verification
REQ-035 SHALL test reset: RESET_PC=32'h0000_0040, release rst_n -> imem_req=1, imem_addr=32'h40 on the first edge; id_valid=0 until response.
REQ-036 SHALL test streaming: one-cycle memory returning 32'h2001_0005, 32'h0022_1820 -> id_op=6'h08, then id_op=0 and id_func=6'h20; id_pc4=32'h44, 32'h48.
REQ-037 SHALL test stall: id_stall=1 for 3 cycles while id_valid=1 -> outputs unchanged and no imem_req; first request follows the cycle id_stall falls.
REQ-038 SHALL test redirect during WAIT: redirect_pc=32'h0000_1002 with 3-cycle memory latency -> stale response dropped, id_valid stays 0, next imem_addr=32'h1000.
REQ-039 SHALL test redirect coinciding with imem_rvalid -> data discarded, next cycle imem_addr=redirect target.
REQ-040 SHALL test wrap: redirect to 32'hFFFF_FFFC -> id_pc4=32'h0, next imem_addr=32'h0.
